oled_digit_arbiter: RTL

Shares the single digit-write port of the OLED display controller between up to eight digit producers, such as classifier instances or a debug source. Requests are granted round-robin into a small FIFO. The FIFO drains one digit at a time into the controller's `in_data_valid` / `in_data` / `sendDone` / `oled_ready` handshake. The block sits between the producers and the controller, holds each digit stable for the whole 8-byte bitmap transfer, and guards against a stalled controller with a watchdog.

---
 rtl/oled_digit_arbiter_if.sv | 24 ++
 rtl/oled_digit_arbiter.sv | 158 +++++++++++++++
 2 files changed

// File: rtl/oled_digit_arbiter_if.sv
// Producer and controller handshake bundle for the OLED digit arbiter.
// The slave side is the arbiter. The master side is whoever drives the
// producers and models the display controller.
interface oled_digit_arbiter_if #(
  parameter int NUM_REQ = 4
);
  logic [NUM_REQ-1:0]   req_valid;
  logic [4*NUM_REQ-1:0] req_digit;
  logic [NUM_REQ-1:0]   req_ready;
  logic                 oled_ready;
  logic                 oled_send_done;
  logic                 oled_data_valid;
  logic [3:0]           oled_data;

  modport slave (
    input  req_valid, req_digit, oled_ready, oled_send_done,
    output req_ready, oled_data_valid, oled_data
  );

  modport master (
    output req_valid, req_digit, oled_ready, oled_send_done,
    input  req_ready, oled_data_valid, oled_data
  );
endinterface

// File: rtl/oled_digit_arbiter.sv
// Round-robin arbiter that merges up to eight digit producers into a small
// FIFO. The FIFO drains one digit at a time into the OLED controller's
// valid/done handshake. The digit is held stable for the whole transfer,
// and a watchdog catches a controller that never reports done.
module oled_digit_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 20000
) (
  input  logic                 clk,
  input  logic                 reset_n,
  oled_digit_arbiter_if.slave  bus,
  output logic                 busy,
  output logic [7:0]           chars_sent,
  output logic                 timeout_err
);

  localparam int              PW      = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int              AW      = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int              CW      = AW + 1;
  localparam logic [CW-1:0]   DEPTH_C = CW'(FIFO_DEPTH);
  localparam logic [PW-1:0]   LAST_RQ = PW'(NUM_REQ - 1);
  // The watchdog fires on the edge that closes cycle TIMEOUT of SEND.
  localparam logic [15:0]     WD_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, SEND, GAP} state_t;

  state_t              state, state_nxt;
  logic [PW-1:0]       rr_ptr, grant_idx;
  logic [NUM_REQ-1:0]  grant;
  logic [3:0]          digit [NUM_REQ];
  logic [3:0]          push_data;
  logic                push, pop, sent, expired;
  int                  scan_idx;
  logic [3:0]          mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic [CW-1:0]       count, count_nxt;
  logic [15:0]         wd;
  logic                data_valid;
  logic [3:0]          data_hold;

  // Split the flat digit bus into one nibble per requester.
  always_comb begin
    for (int k = 0; k < NUM_REQ; k++) digit[k] = bus.req_digit[4*k +: 4];
  end

  // Round-robin search from rr_ptr. The scan runs backwards so that the
  // closest requester to rr_ptr is written last and wins.
  always_comb begin
    grant     = '0;
    grant_idx = '0;
    push_data = '0;
    scan_idx  = 0;
    if (count != DEPTH_C) begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        scan_idx = int'(rr_ptr) + k;
        if (scan_idx >= NUM_REQ) scan_idx = scan_idx - NUM_REQ;
        if (bus.req_valid[PW'(scan_idx)]) begin
          grant                 = '0;
          grant[PW'(scan_idx)]  = 1'b1;
          grant_idx             = PW'(scan_idx);
          push_data             = digit[PW'(scan_idx)];
        end
      end
    end
  end

  assign bus.req_ready       = grant;
  assign push                = |grant;
  assign bus.oled_data_valid = data_valid;
  assign bus.oled_data       = data_hold;

  // Drain FSM: next state and per-cycle strobes. Done wins over an
  // expiring watchdog when both arrive in the same cycle.
  always_comb begin
    state_nxt = state;
    pop       = 1'b0;
    sent      = 1'b0;
    expired   = 1'b0;
    case (state)
      IDLE: if (bus.oled_ready && count != '0) begin
        pop       = 1'b1;
        state_nxt = SEND;
      end
      SEND: if (bus.oled_send_done) begin
        sent      = 1'b1;
        state_nxt = GAP;
      end else if (wd == WD_LAST) begin
        expired   = 1'b1;
        state_nxt = GAP;
      end
      // Hold off until the controller drops done, so it never re-samples
      // valid while done is still high.
      GAP: if (!bus.oled_send_done) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FIFO occupancy after this edge. A push is only possible below full.
  always_comb begin
    case ({push, pop})
      2'b10:   count_nxt = count + 1'b1;
      2'b01:   count_nxt = count - 1'b1;
      default: count_nxt = count;
    endcase
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= IDLE;
    else          state <= state_nxt;
  end

  // Round-robin pointer moves past the requester that was just served.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)  rr_ptr <= '0;
    else if (push) rr_ptr <= (grant_idx == LAST_RQ) ? '0 : grant_idx + 1'b1;
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count_nxt;
    end
  end

  // FIFO storage. It needs no reset because the pointers gate every read.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= push_data;
  end

  // Registered outputs, watchdog and status counters.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      data_valid  <= 1'b0;
      data_hold   <= '0;
      wd          <= '0;
      chars_sent  <= '0;
      timeout_err <= 1'b0;
      busy        <= 1'b0;
    end else begin
      data_valid <= (state_nxt == SEND);
      busy       <= (state_nxt != IDLE) || (count_nxt != '0);
      if (pop) data_hold <= mem[rd_ptr];
      if (pop)                wd <= '0;
      else if (state == SEND) wd <= wd + 16'd1;
      if (sent)    chars_sent  <= chars_sent + 8'd1;
      if (expired) timeout_err <= 1'b1;
    end
  end

endmodule
